terminal_write_ctrl: RTL

Byte-stream controller for the 80x30 text terminal. It sits between the UART receiver and the character-RAM write port. It decodes each received byte into a printable-character write, a cursor move or a colour change. It owns the cursor and sequences multi-cycle operations (backspace, clear screen). It is the only writer of character RAM; the VGA scan-out uses the independent read port.

---
 rtl/terminal_write_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/terminal_write_ctrl.sv
// Byte-stream controller for the 80x30 text terminal: decodes UART bytes into char-RAM writes, cursor moves and colour changes.
// Optional full-screen clear on 0x0C is built only when TERMINAL_CLEAR_EN is defined; otherwise 0x0C homes the cursor.
module terminal_write_ctrl #(
    parameter int CLOCK_HZ = 10_000_000,
    parameter int COLS     = 80,
    parameter int ROWS     = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Valid_i,
    input  logic [7:0]  Data_i,
    output logic        Ready_o,
    output logic        WriteEnable_o,
    output logic [11:0] WriteAddress_o,
    output logic [7:0]  WriteData_o,
    output logic [2:0]  Color_o,
    output logic        ColorWE_o,
    output logic [6:0]  CursorX_o,
    output logic [4:0]  CursorY_o,
    output logic        Overflow_o
);

    // The linear address uses a fixed shift-add for 80 columns.
    if (COLS != 80 || ROWS > 32 || CLOCK_HZ <= 0) begin : g_cfg_check
        $error("terminal_write_ctrl: unsupported configuration");
    end

    localparam logic [6:0]  LAST_X    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_Y    = 5'(ROWS - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

`ifdef TERMINAL_CLEAR_EN
    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
    typedef enum logic [1:0] {IDLE, BKSP, CLEAR} state_t;
    logic [11:0] clr_cnt;
`else
    typedef enum logic [1:0] {IDLE, BKSP} state_t;
`endif

    state_t state;

    function automatic logic [11:0] lin_addr(input logic [6:0] cx, input logic [4:0] cy);
        logic [11:0] y12;
        y12 = {7'd0, cy};
        return (y12 << 6) + (y12 << 4) + {5'd0, cx};
    endfunction

    assign Ready_o = (state == IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            WriteEnable_o  <= 1'b0;
            WriteAddress_o <= 12'd0;
            WriteData_o    <= 8'd0;
            Color_o        <= 3'b111;
            ColorWE_o      <= 1'b0;
            CursorX_o      <= 7'd0;
            CursorY_o      <= 5'd0;
            Overflow_o     <= 1'b0;
`ifdef TERMINAL_CLEAR_EN
            clr_cnt        <= 12'd0;
`endif
        end else begin
            WriteEnable_o <= 1'b0;
            ColorWE_o     <= 1'b0;

            // Bytes arriving during BKSP/CLEAR are lost; remember that it happened.
            if (Valid_i && state != IDLE)
                Overflow_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (Valid_i) begin
                        if (Data_i <= 8'h07) begin
                            Color_o   <= Data_i[2:0];
                            ColorWE_o <= 1'b1;
                        end else begin
                            case (Data_i)
                                8'h08: begin
                                    if (CursorX_o != 7'd0) begin
                                        CursorX_o <= CursorX_o - 7'd1;
                                    end else if (CursorY_o != 5'd0) begin
                                        CursorX_o <= LAST_X;
                                        CursorY_o <= CursorY_o - 5'd1;
                                    end
                                    state <= BKSP;
                                end
                                8'h0A: begin
                                    CursorY_o <= (CursorY_o == LAST_Y) ? 5'd0 : CursorY_o + 5'd1;
                                end
                                8'h0D: begin
                                    CursorX_o <= 7'd0;
                                end
                                8'h0C: begin
`ifdef TERMINAL_CLEAR_EN
                                    clr_cnt <= 12'd0;
                                    state   <= CLEAR;
`else
                                    CursorX_o <= 7'd0;
                                    CursorY_o <= 5'd0;
`endif
                                end
                                8'h1B: begin
                                    CursorX_o <= 7'd0;
                                    CursorY_o <= 5'd0;
                                end
                                default: begin
                                    WriteEnable_o  <= 1'b1;
                                    WriteAddress_o <= lin_addr(CursorX_o, CursorY_o);
                                    WriteData_o    <= Data_i;
                                    if (CursorX_o == LAST_X) begin
                                        CursorX_o <= 7'd0;
                                        CursorY_o <= (CursorY_o == LAST_Y) ? 5'd0 : CursorY_o + 5'd1;
                                    end else begin
                                        CursorX_o <= CursorX_o + 7'd1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                // Cursor already retreated on entry; blank the cell it now points at.
                BKSP: begin
                    WriteEnable_o  <= 1'b1;
                    WriteAddress_o <= lin_addr(CursorX_o, CursorY_o);
                    WriteData_o    <= SPACE;
                    state          <= IDLE;
                end

`ifdef TERMINAL_CLEAR_EN
                CLEAR: begin
                    WriteEnable_o  <= 1'b1;
                    WriteAddress_o <= clr_cnt;
                    WriteData_o    <= SPACE;
                    if (clr_cnt == LAST_ADDR) begin
                        CursorX_o <= 7'd0;
                        CursorY_o <= 5'd0;
                        state     <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 12'd1;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule
